// File: rtl/msrv32_alu_arbiter.sv
// Round-robin arbiter sharing one combinational msrv32 ALU between the
// integer pipeline (requester 0) and the address/CSR helper (requester 1).
// One operation in flight: IDLE accepts, EXEC drives the ALU for one cycle,
// RESP holds the registered result until the owner takes it.
module msrv32_alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              req0_valid_in,
  input  logic [DATA_W-1:0] req0_op1_in,
  input  logic [DATA_W-1:0] req0_op2_in,
  input  logic [3:0]        req0_opcode_in,
  output logic              req0_ready_out,
  input  logic              req1_valid_in,
  input  logic [DATA_W-1:0] req1_op1_in,
  input  logic [DATA_W-1:0] req1_op2_in,
  input  logic [3:0]        req1_opcode_in,
  output logic              req1_ready_out,
  output logic              rsp0_valid_out,
  output logic              rsp1_valid_out,
  input  logic              rsp0_ready_in,
  input  logic              rsp1_ready_in,
  output logic [DATA_W-1:0] rsp_result_out,
  output logic              rsp_err_out,
  output logic [DATA_W-1:0] alu_op_1_out,
  output logic [DATA_W-1:0] alu_op_2_out,
  output logic [3:0]        alu_opcode_out,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              busy_out,
  output logic [CNT_W-1:0]  op_count_out
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_owner;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [3:0]        r_opcode;
  logic [DATA_W-1:0] r_result;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_rsp_take;
  logic              w_illegal;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant0 = req0_valid_in & (~req1_valid_in | r_last_grant);
    w_grant1 = req1_valid_in & (~req0_valid_in | ~r_last_grant);
  end

  // Ready is also masked by reset so nothing is offered while reset is held.
  assign req0_ready_out = (r_state == IDLE) & w_grant0 & ~ms_riscv32_mp_rst_in;
  assign req1_ready_out = (r_state == IDLE) & w_grant1 & ~ms_riscv32_mp_rst_in;
  assign w_accept       = req0_ready_out | req1_ready_out;
  assign w_rsp_take     = (r_state == RESP) & (r_owner ? rsp1_ready_in : rsp0_ready_in);

  // Opcodes the msrv32 ALU implements; anything else is flagged as an error.
  always_comb begin
    case (r_opcode)
      4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
      4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101: w_illegal = 1'b0;
      default:                                     w_illegal = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_take) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) r_state <= IDLE;
    else                      r_state <= w_next;
  end

  // Operand capture on accept, result capture at end of EXEC, completion count.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_opcode     <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant1;
        r_last_grant <= w_grant1;
        r_op1        <= w_grant1 ? req1_op1_in    : req0_op1_in;
        r_op2        <= w_grant1 ? req1_op2_in    : req0_op2_in;
        r_opcode     <= w_grant1 ? req1_opcode_in : req0_opcode_in;
      end
      if (r_state == EXEC) begin
        r_err    <= w_illegal;
        r_result <= w_illegal ? '0 : alu_result_in;
      end
      if (w_rsp_take && (r_count != '1)) r_count <= r_count + CNT_W'(1);
    end
  end

  assign alu_op_1_out   = (r_state == EXEC) ? r_op1    : '0;
  assign alu_op_2_out   = (r_state == EXEC) ? r_op2    : '0;
  assign alu_opcode_out = (r_state == EXEC) ? r_opcode : '0;
  assign rsp0_valid_out = (r_state == RESP) & ~r_owner;
  assign rsp1_valid_out = (r_state == RESP) &  r_owner;
  assign rsp_result_out = r_result;
  assign rsp_err_out    = r_err;
  assign busy_out       = (r_state != IDLE);
  assign op_count_out   = r_count;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench for msrv32_alu_arbiter: a stub ALU answers the arbiter's ALU port,
// a vector table exercises single-requester operations, and hand-written
// sequences cover tie alternation, response back-pressure and mid-op reset.
module tb_msrv32_alu_arbiter;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;   // narrow so saturation is reached quickly

  logic              clk;
  logic              rst;
  logic              req0_valid_in, req1_valid_in;
  logic [DATA_W-1:0] req0_op1_in, req0_op2_in, req1_op1_in, req1_op2_in;
  logic [3:0]        req0_opcode_in, req1_opcode_in;
  logic              req0_ready_out, req1_ready_out;
  logic              rsp0_valid_out, rsp1_valid_out;
  logic              rsp0_ready_in, rsp1_ready_in;
  logic [DATA_W-1:0] rsp_result_out;
  logic              rsp_err_out;
  logic [DATA_W-1:0] alu_op_1_out, alu_op_2_out, alu_result_in;
  logic [3:0]        alu_opcode_out;
  logic              busy_out;
  logic [CNT_W-1:0]  op_count_out;

  msrv32_alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .req0_valid_in        (req0_valid_in),
    .req0_op1_in          (req0_op1_in),
    .req0_op2_in          (req0_op2_in),
    .req0_opcode_in       (req0_opcode_in),
    .req0_ready_out       (req0_ready_out),
    .req1_valid_in        (req1_valid_in),
    .req1_op1_in          (req1_op1_in),
    .req1_op2_in          (req1_op2_in),
    .req1_opcode_in       (req1_opcode_in),
    .req1_ready_out       (req1_ready_out),
    .rsp0_valid_out       (rsp0_valid_out),
    .rsp1_valid_out       (rsp1_valid_out),
    .rsp0_ready_in        (rsp0_ready_in),
    .rsp1_ready_in        (rsp1_ready_in),
    .rsp_result_out       (rsp_result_out),
    .rsp_err_out          (rsp_err_out),
    .alu_op_1_out         (alu_op_1_out),
    .alu_op_2_out         (alu_op_2_out),
    .alu_opcode_out       (alu_opcode_out),
    .alu_result_in        (alu_result_in),
    .busy_out             (busy_out),
    .op_count_out         (op_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU; illegal opcodes return a junk pattern the arbiter must not pass on.
  always_comb begin
    case (alu_opcode_out)
      4'b0000: alu_result_in = alu_op_1_out + alu_op_2_out;
      4'b1000: alu_result_in = alu_op_1_out - alu_op_2_out;
      4'b0010: alu_result_in = {31'b0, alu_op_1_out < alu_op_2_out};
      4'b0011: alu_result_in = {31'b0, $signed(alu_op_1_out) < $signed(alu_op_2_out)};
      4'b0111: alu_result_in = alu_op_1_out & alu_op_2_out;
      4'b0110: alu_result_in = alu_op_1_out | alu_op_2_out;
      4'b0100: alu_result_in = alu_op_1_out ^ alu_op_2_out;
      4'b0001: alu_result_in = alu_op_1_out >> alu_op_2_out[4:0];
      4'b0101: alu_result_in = alu_op_1_out << alu_op_2_out[4:0];
      4'b1101: alu_result_in = $unsigned($signed(alu_op_1_out) >>> alu_op_2_out[4:0]);
      default: alu_result_in = 32'hDEAD_BEEF;
    endcase
  end

  int               n_vec = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;
  int               exp_last;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one operation whose valid is already driven; expects requester eo to win.
  task automatic txn(input int eo, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] opc, input logic [31:0] eres, input logic eerr);
    int got;
    got = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("ready_exclusive", {31'b0, req0_ready_out & req1_ready_out}, 32'd0);
      if (req0_ready_out) begin got = 0; break; end
      if (req1_ready_out) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (got < 0) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: got no ready expected ready for req%0d", eo);
      req0_valid_in = 1'b0; req1_valid_in = 1'b0;
      return;
    end
    chk("grant_owner", got, eo);
    exp_last = got;
    @(posedge clk); #1;
    if (got == 0) req0_valid_in = 1'b0; else req1_valid_in = 1'b0;
    chk("exec_busy", {31'b0, busy_out}, 32'd1);
    chk("exec_alu_op1", alu_op_1_out, a);
    chk("exec_alu_op2", alu_op_2_out, b);
    chk("exec_alu_opcode", {28'b0, alu_opcode_out}, {28'b0, opc});
    chk("exec_no_ready", {30'b0, req0_ready_out, req1_ready_out}, 32'd0);
    chk("exec_no_rsp", {30'b0, rsp0_valid_out, rsp1_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("resp_valid", {30'b0, rsp1_valid_out, rsp0_valid_out}, (got == 0) ? 32'd1 : 32'd2);
    chk("resp_result", rsp_result_out, eres);
    chk("resp_err", {31'b0, rsp_err_out}, {31'b0, eerr});
    chk("resp_alu_idle", alu_op_1_out | {28'b0, alu_opcode_out}, 32'd0);
    if (got == 0) rsp0_ready_in = 1'b1; else rsp1_ready_in = 1'b1;
    @(posedge clk); #1;
    rsp0_ready_in = 1'b0; rsp1_ready_in = 1'b0;
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    chk("op_count", {29'b0, op_count_out}, {29'b0, exp_cnt});
    chk("idle_after_take", {31'b0, busy_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0, 32'd5,          32'd3,          4'b0000, 32'd8,          1'b0};
    tv[1] = '{1, 32'hFFFF_FFF0,  32'd4,          4'b1101, 32'hFFFF_FFFF,  1'b0};
    tv[2] = '{1, 32'hFFFF_FFF0,  32'd4,          4'b0001, 32'h0FFF_FFFF,  1'b0};
    tv[3] = '{0, 32'h1234_5678,  32'd9,          4'b1111, 32'd0,          1'b1};
    tv[4] = '{0, 32'hFFFF_FFFF,  32'd1,          4'b0011, 32'd1,          1'b0};
    tv[5] = '{1, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b0};
    tv[6] = '{0, 32'h0000_1234,  32'h0000_0F0F,  4'b1000, 32'h0000_0325,  1'b0};
    tv[7] = '{1, 32'hAAAA_5555,  32'h0F0F_0F0F,  4'b0100, 32'hA5A5_5A5A,  1'b0};
    tv[8] = '{1, 32'h0000_0055,  32'h0000_0066,  4'b1010, 32'd0,          1'b1};
    tv[9] = '{0, 32'h0000_F0F0,  32'h0000_FF00,  4'b0111, 32'h0000_F000,  1'b0};

    rst = 1'b1;
    req0_valid_in = 1'b1; req1_valid_in = 1'b0;
    req0_op1_in = '0; req0_op2_in = '0; req0_opcode_in = '0;
    req1_op1_in = '0; req1_op2_in = '0; req1_opcode_in = '0;
    rsp0_ready_in = 1'b0; rsp1_ready_in = 1'b0;
    exp_cnt = '0; exp_last = 1;

    // Reset state, with a request pending that must not be offered ready.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", {30'b0, req0_ready_out, req1_ready_out}, 32'd0);
    chk("rst_busy", {31'b0, busy_out}, 32'd0);
    chk("rst_count", {29'b0, op_count_out}, 32'd0);
    chk("rst_result", rsp_result_out, 32'd0);
    chk("rst_err", {31'b0, rsp_err_out}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp0_valid_out, rsp1_valid_out}, 32'd0);
    chk("rst_alu", alu_op_1_out | alu_op_2_out | {28'b0, alu_opcode_out}, 32'd0);
    rst = 1'b0;
    req0_valid_in = 1'b0;
    @(posedge clk); #1;

    // Single-requester vectors.
    for (int i = 0; i < 10; i++) begin
      if (tv[i].req == 0) begin
        req0_op1_in = tv[i].a; req0_op2_in = tv[i].b; req0_opcode_in = tv[i].opc;
        req0_valid_in = 1'b1;
      end else begin
        req1_op1_in = tv[i].a; req1_op2_in = tv[i].b; req1_opcode_in = tv[i].opc;
        req1_valid_in = 1'b1;
      end
      txn(tv[i].req, tv[i].a, tv[i].b, tv[i].opc, tv[i].res, tv[i].err);
    end

    // Both requesting continuously: grants alternate, starting opposite the last winner.
    req0_op1_in = 32'd100; req0_op2_in = 32'd23; req0_opcode_in = 4'b0110;
    req1_op1_in = 32'd100; req1_op2_in = 32'd23; req1_opcode_in = 4'b1000;
    req0_valid_in = 1'b1; req1_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (exp_last == 0) txn(1, 32'd100, 32'd23, 4'b1000, 32'd77, 1'b0);
      else               txn(0, 32'd100, 32'd23, 4'b0110, 32'd119, 1'b0);
      req0_valid_in = 1'b1; req1_valid_in = 1'b1;
    end
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    @(posedge clk); #1;

    // Response back-pressure: owner 0 withholds ready while req1 waits.
    req0_op1_in = 32'd7; req0_op2_in = 32'd8; req0_opcode_in = 4'b0000;
    req0_valid_in = 1'b1;
    #1;
    chk("hold_accept0", {31'b0, req0_ready_out}, 32'd1);
    @(posedge clk); #1;
    req0_valid_in = 1'b0;
    req0_op1_in = 32'd999;   // changes after accept must not reach the ALU
    req1_op1_in = 32'd3; req1_op2_in = 32'd5; req1_opcode_in = 4'b0110;
    req1_valid_in = 1'b1;
    chk("hold_latched_op1", alu_op_1_out, 32'd7);
    @(posedge clk); #1;
    rsp1_ready_in = 1'b1;    // non-owner ready must be ignored
    for (int c = 0; c < 10; c++) begin
      chk("hold_rsp0_valid", {30'b0, rsp1_valid_out, rsp0_valid_out}, 32'd1);
      chk("hold_no_ready1", {31'b0, req1_ready_out}, 32'd0);
      chk("hold_result", rsp_result_out, 32'd15);
      @(posedge clk); #1;
    end
    rsp1_ready_in = 1'b0;
    rsp0_ready_in = 1'b1;
    @(posedge clk); #1;
    rsp0_ready_in = 1'b0;
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    exp_last = 0;
    chk("hold_count_sat", {29'b0, op_count_out}, {29'b0, exp_cnt});
    #1;
    chk("hold_accept1_next", {31'b0, req1_ready_out}, 32'd1);
    txn(1, 32'd3, 32'd5, 4'b0110, 32'd7, 1'b0);

    // Reset during EXEC discards the operation and restores the tie-break.
    req0_op1_in = 32'd9; req0_op2_in = 32'd9; req0_opcode_in = 4'b0000;
    req0_valid_in = 1'b1;
    #1;
    chk("mid_rst_accept", {31'b0, req0_ready_out}, 32'd1);
    @(posedge clk); #1;
    req0_op1_in = 32'd2; req0_op2_in = 32'd2;
    req1_op1_in = 32'd50; req1_op2_in = 32'd1; req1_opcode_in = 4'b0000;
    req1_valid_in = 1'b1;
    chk("mid_rst_in_exec", {31'b0, busy_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy_out}, 32'd0);
    chk("mid_rst_ready", {30'b0, req0_ready_out, req1_ready_out}, 32'd0);
    chk("mid_rst_alu", alu_op_1_out | alu_op_2_out | {28'b0, alu_opcode_out}, 32'd0);
    chk("mid_rst_result", rsp_result_out, 32'd0);
    chk("mid_rst_count", {29'b0, op_count_out}, 32'd0);
    exp_cnt = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", {30'b0, rsp0_valid_out, rsp1_valid_out}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_no_rsp", {30'b0, rsp0_valid_out, rsp1_valid_out}, 32'd0);
    txn(0, 32'd2, 32'd2, 4'b0000, 32'd4, 1'b0);
    req1_valid_in = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
